// File: rtl/serial_parity_checker.sv
// serial_parity_checker: folds a bit-serial frame (FRAME_LEN data bits, MSB
// first, then one parity bit) through a running XOR accumulator and reports
// the deserialised word, a parity-error flag and a one-cycle done pulse.
// Optional feature macro: SERIAL_PARITY_ERR_CNT_EN (saturating error counter;
// when undefined err_count is tied to zero).
//
// Handshake: a beat is any cycle with bit_valid=1; bit_in and sof are only
// looked at on beats. There is no backpressure, every beat is consumed.
module serial_parity_checker #(
    parameter int FRAME_LEN = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 sof,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FRAME_LEN-1:0] data_out,
    output logic                 parity_err,
    output logic                 abort,
    output logic [7:0]           err_count
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state, state_next;
    logic                 acc, acc_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [FRAME_LEN-1:0] shreg, shreg_next;
    logic [FRAME_LEN-1:0] data_next;
    logic                 perr_next;
    logic                 done_next;
    logic                 abort_next;

    // Next-state and datapath decode; idle cycles (bit_valid=0) hold everything.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        shreg_next = shreg;
        data_next  = data_out;
        perr_next  = parity_err;
        done_next  = 1'b0;
        abort_next = 1'b0;
        if (bit_valid) begin
            if (sof) begin
                // sof always starts a fresh frame; any partial frame is dropped.
                abort_next = (state != IDLE);
                shreg_next = FRAME_LEN'(bit_in);
                acc_next   = bit_in;
                cnt_next   = CNT_W'(1);
                state_next = (FRAME_LEN == 1) ? PARITY : DATA;
            end else begin
                case (state)
                    DATA: begin
                        shreg_next = (shreg << 1) | FRAME_LEN'(bit_in);
                        acc_next   = acc ^ bit_in;
                        cnt_next   = cnt + CNT_W'(1);
                        if (cnt_next == CNT_W'(FRAME_LEN)) begin
                            state_next = PARITY;
                        end
                    end
                    PARITY: begin
                        perr_next  = acc ^ bit_in ^ ODD;
                        data_next  = shreg;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State register and frame-assembly datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            shreg <= shreg_next;
        end
    end

    // Registered outputs; busy is taken from the next state so it tracks state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
        end else begin
            busy       <= (state_next != IDLE);
            frame_done <= done_next;
            abort      <= abort_next;
            data_out   <= data_next;
            parity_err <= perr_next;
        end
    end

`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating parity-error counter, advanced with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (done_next && perr_next && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Testbench for serial_parity_checker: an even-parity and an odd-parity
// instance share one input stream; a queue-based frame model predicts every
// output after every cycle.
module tb_serial_parity_checker;

    localparam int FL = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic bit_valid = 1'b0;
    logic bit_in    = 1'b0;
    logic sof       = 1'b0;

    logic          busy_e, done_e, perr_e, abort_e;
    logic [FL-1:0] data_e;
    logic [7:0]    ecnt_e;
    logic          busy_o, done_o, perr_o, abort_o;
    logic [FL-1:0] data_o;
    logic [7:0]    ecnt_o;

    serial_parity_checker #(.FRAME_LEN(FL), .ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
        .busy(busy_e), .frame_done(done_e), .data_out(data_e),
        .parity_err(perr_e), .abort(abort_e), .err_count(ecnt_e)
    );

    serial_parity_checker #(.FRAME_LEN(FL), .ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
        .busy(busy_o), .frame_done(done_o), .data_out(data_o),
        .parity_err(perr_o), .abort(abort_o), .err_count(ecnt_o)
    );

    // ---------------- scoreboard / model state ----------------
    int n_asserts = 0;
    int n_fails   = 0;
    int n_done_seen  = 0;
    int n_abort_seen = 0;

    logic [FL-1:0] exp_q[$];     // words of completed frames, in order
    logic          mq[$];        // bits received since the last sof
    logic [FL-1:0] m_data = '0;
    logic          m_perr_e = 1'b0;
    logic          m_perr_o = 1'b0;
    int            m_ecnt_e = 0;
    int            m_ecnt_o = 0;
    logic          m_done, m_abort, m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        return (v < 255) ? v + 1 : 255;
`else
        return 0;
`endif
    endfunction

    // Reference behaviour: a frame is "sof bit + FL-1 bits + parity bit".
    task automatic model_beat(input logic s, input logic b);
        logic [FL-1:0] word;
        logic          x;
        if (s) begin
            if (mq.size() > 0) m_abort = 1'b1;
            mq.delete();
            mq.push_back(b);
        end else if (mq.size() > 0) begin
            mq.push_back(b);
            if (mq.size() == FL + 1) begin
                word = '0;
                x    = 1'b0;
                for (int i = 0; i < FL; i++) begin
                    word = {word[FL-2:0], mq[i]};
                    x    = x ^ mq[i];
                end
                m_data   = word;
                m_perr_e = x ^ mq[FL];
                m_perr_o = ~(x ^ mq[FL]);
                if (m_perr_e) m_ecnt_e = sat_inc(m_ecnt_e);
                if (m_perr_o) m_ecnt_o = sat_inc(m_ecnt_o);
                m_done = 1'b1;
                exp_q.push_back(word);
                mq.delete();
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic s, input logic b);
        bit_valid = v;
        sof       = s;
        bit_in    = b;
        m_done    = 1'b0;
        m_abort   = 1'b0;
        if (v) model_beat(s, b);
        m_busy = (mq.size() > 0);
        @(posedge clk);
        #1;
        chk("done", done_e, m_done);
        chk("abort", abort_e, m_abort);
        chk("busy", busy_e, m_busy);
        chk("data", data_e, m_data);
        chk("perr", perr_e, m_perr_e);
        chk("ecnt", ecnt_e, m_ecnt_e);
        chk("odd_done", done_o, m_done);
        chk("odd_abort", abort_o, m_abort);
        chk("odd_perr", perr_o, m_perr_o);
        chk("odd_ecnt", ecnt_o, m_ecnt_o);
        if (done_e) begin
            n_done_seen++;
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("sb_data", data_e, exp_q.pop_front());
        end
        if (abort_e) n_abort_seen++;
    endtask

    task automatic send_frame(input logic [FL-1:0] word, input logic pbit,
                              input int gap_after, input int gap_len);
        for (int i = 0; i < FL; i++) begin
            step(1'b1, (i == 0), word[FL-1-i]);
            if (i + 1 == gap_after) begin
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end
        end
        step(1'b1, 1'b0, pbit);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'b0;
        sof       = 1'b0;
        bit_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        m_data = '0; m_perr_e = 1'b0; m_perr_o = 1'b0;
        m_ecnt_e = 0; m_ecnt_o = 0;
        chk("rst_busy", busy_e, 0);
        chk("rst_done", done_e, 0);
        chk("rst_abort", abort_e, 0);
        chk("rst_data", data_e, 0);
        chk("rst_perr", perr_e, 0);
        chk("rst_ecnt", ecnt_e, 0);
        chk("rst_odd_perr", perr_o, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d0, a0;
        logic [FL-1:0] w;

        do_reset();

        // Clean frame 0xA5, even parity bit 0.
        send_frame(8'hA5, 1'b0, 0, 0);
        chk("clean_done", done_e, 1);
        chk("clean_data", data_e, 8'hA5);
        chk("clean_perr", perr_e, 0);
        chk("clean_busy", busy_e, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("clean_done_one_cycle", done_e, 0);

        // Bad parity with a 3-cycle gap between bits 4 and 5.
        send_frame(8'hA5, 1'b1, 4, 3);
        chk("bad_data", data_e, 8'hA5);
        chk("bad_perr", perr_e, 1);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        chk("bad_ecnt", ecnt_e, 1);
`else
        chk("bad_ecnt", ecnt_e, 0);
`endif

        // Odd parity: 0x01 with parity 0 is correct for the odd instance.
        send_frame(8'h01, 1'b0, 0, 0);
        chk("odd_ok_perr", perr_o, 0);
        chk("odd_ok_data", data_o, 8'h01);

        // Abort: five bits of 0xFF, then a new frame 0x3C.
        d0 = n_done_seen;
        a0 = n_abort_seen;
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1);
        send_frame(8'h3C, 1'b0, 0, 0);
        chk("abort_count", n_abort_seen - a0, 1);
        chk("abort_done_count", n_done_seen - d0, 1);
        chk("abort_data", data_e, 8'h3C);
        chk("abort_perr", perr_e, 0);

        // Reset after bit 3, then a clean 0x5A frame.
        for (int i = 0; i < 3; i++) step(1'b1, (i == 0), w[0]);
        do_reset();
        d0 = n_done_seen;
        a0 = n_abort_seen;
        send_frame(8'h5A, 1'b0, 0, 0);
        chk("rstmid_data", data_e, 8'h5A);
        chk("rstmid_perr", perr_e, 0);
        chk("rstmid_done_count", n_done_seen - d0, 1);
        chk("rstmid_abort_count", n_abort_seen - a0, 0);

        // Back-to-back frames plus random gaps.
        for (int f = 0; f < 20; f++) begin
            w = FL'($urandom);
            send_frame(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, FL)),
                       int'($urandom_range(0, 3)));
        end

        // Fully random beats: sof anywhere, gaps anywhere.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)));
        end

        // Saturation: 260 back-to-back frames with bad even parity.
        do_reset();
        for (int f = 0; f < 260; f++) begin
            w = FL'($urandom);
            send_frame(w, ~(^w), 0, 0);
        end
`ifdef SERIAL_PARITY_ERR_CNT_EN
        chk("sat_ecnt", ecnt_e, 255);
`else
        chk("sat_ecnt", ecnt_e, 0);
`endif
        chk("sat_odd_ecnt", ecnt_o, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Serial-stream parity checker that consumes a bit-serial stream and verifies frame parity with a running XOR accumulator. Sits directly downstream of the XOR gate primitive in the datapath: the gate's `a ^ b` function is applied once per accepted bit to fold the frame into a single parity bit. Frames are FRAME_LEN data bits, MSB first, followed by one parity bit. The block reports the deserialised word, a parity-error flag and a one-cycle completion pulse.

## Interface
- `FRAME_LEN`, 8: data bits per frame; legal range 1..32.
- `ODD`, 0: 0 = even parity (XOR of data and parity bits must be 0); 1 = odd parity (must be 1).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_valid`  in  1  `bit_in` is accepted on this cycle.
- `bit_in`  in  1  serial data or parity bit.
- `sof`  in  1  start of frame; qualified by `bit_valid`; marks the first data bit.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `data_out`  out  FRAME_LEN  deserialised data word; held until the next `frame_done`.
- `parity_err`  out  1  parity result of the last completed frame; held until the next `frame_done`.
- `abort`  out  1  one-cycle pulse when an in-progress frame is discarded by `sof`.
- `err_count`  out  8  saturating count of parity errors; see Configuration.

## Operation
- Internal state:
  - `acc`: 1-bit running XOR accumulator.
  - `cnt`: bit counter, clog2(FRAME_LEN+1) bits wide.
  - `shreg`: FRAME_LEN-bit shift register; each new bit enters at the LSB, so the first bit ends at the MSB.
- A beat is any cycle with `bit_valid`=1. Cycles with `bit_valid`=0 change nothing in the state machine.
- **IDLE**
  - A beat with `sof`=1 loads `shreg`, sets `acc`=`bit_in` and `cnt`=1, then moves to PARITY if FRAME_LEN==1, otherwise to DATA.
  - A beat with `sof`=0 is ignored.
- **DATA**
  - Each beat with `sof`=0 shifts `shreg`, updates `acc ^= bit_in` and increments `cnt`.
  - The beat that makes `cnt`==FRAME_LEN moves to PARITY.
- **PARITY**
  - A beat with `sof`=0 is the parity bit.
  - On that beat: `parity_err` <= `acc ^ bit_in ^ ODD`, `data_out` <= `shreg`, `frame_done` pulses, state returns to IDLE.
- **`sof` mid-frame** (DATA or PARITY, beat with `sof`=1)
  - `abort` pulses and the partial frame is discarded.
  - The beat is treated as the first bit of a new frame, with the same actions as IDLE+`sof`.
  - `data_out`, `parity_err` and `err_count` are unchanged.
- `busy` = (state ≠ IDLE), registered.

## Timing
- Reset values:
  - Outputs: `busy`=0, `frame_done`=0, `abort`=0, `data_out`=0, `parity_err`=0, `err_count`=0.
  - Internal: state=IDLE, `acc`=0, `cnt`=0.
- All outputs are registered.
- `frame_done`, `data_out` and `parity_err` update on the clock edge that samples the parity beat, so they are visible in the following cycle.
- `frame_done` and `abort` are high for exactly one cycle.
- Minimum frame duration is FRAME_LEN+1 consecutive beats; back-to-back frames need no idle cycle.
- A `sof` beat in the cycle after a parity beat starts the next frame with no bubble.
- Reset asserted mid-frame discards the frame, and no `frame_done` or `abort` is produced.

## Configuration
- `SERIAL_PARITY_ERR_CNT_EN`
  - **Defined:** `err_count` increments by 1 in the same cycle that `frame_done` and `parity_err`=1 are produced. It saturates at 255 and is cleared only by `rst`.
  - **Undefined:** the counter logic is absent; the `err_count` port still exists and is tied to 0.

## Test plan
All scenarios use FRAME_LEN=8 and ODD=0 unless stated otherwise.
- **Clean frame:** `sof` on bit 1, send 0xA5 MSB first, then parity 0, all beats contiguous. Required: `frame_done` pulses one cycle after the parity beat, `data_out`=0xA5, `parity_err`=0, `busy` falls in the same cycle.
- **Bad parity with gaps:** send 0xA5 with parity 1, holding `bit_valid` low for 3 cycles between bits 4 and 5. Required: `data_out`=0xA5, `parity_err`=1, `err_count`=1 (with the macro) or 0 (without).
- **Odd parity:** ODD=1, send 0x01 with parity 0. Required: `parity_err`=0.
- **Abort:** send 5 bits of 0xFF, then a `sof` beat followed by 0x3C and parity 0. Required: `abort` pulses once, a single `frame_done` follows with `data_out`=0x3C and `parity_err`=0.
- **Reset mid-frame:** assert `rst` after bit 3, then send a clean 0x5A frame. Required: after reset all outputs are 0; the subsequent frame yields `data_out`=0x5A, `parity_err`=0, and no stray pulses.
- **Saturation:** with the macro defined, send 260 back-to-back frames with bad parity. Required: `err_count` stops at 255.
